minute_hand_tracker: RTL
========================

// Module: minute_hand_tracker
// PURPOSE
//   Consumes the minute-toggle from the minute counter stage (one full toggle period = 1 min)
//   and keeps wall-clock minute (0-59) and hour (0-11) state in the system clock domain.
//   Produces the minute and hour hand positions (0-59 ticks on the dial) for the display stage.
//   Supports manual advance and a valid/ready time-set interface.
// PARAMETERS
//   SYNC_STAGES   2   flops in the minuteToggle synchroniser (>=2)
//   CHIME_CYCLES  8   width in clocks of the hour chime pulse (CHIME_EN builds only)
// PORTS
//   clock         in   1  system clock; all state on rising edge
//   reset         in   1  asynchronous, active-high reset
//   minuteToggle  in   1  toggle from minute counter; asynchronous to clock
//   advance       in   1  1-cycle pulse: step time forward one minute
//   setValid      in   1  set request
//   setMinute     in   6  minute to load (0-59 legal)
//   setHour       in   4  hour to load (0-11 legal)
//   setReady      out  1  set request accepted when setValid & setReady
//   setError      out  1  1-cycle pulse: accepted set had out-of-range value
//   minuteOut     out  6  current minute, 0-59
//   hourOut       out  4  current hour, 0-11
//   hourHandPos   out  6  hourOut*5 + minuteOut/12 (integer divide), 0-59
//   chime         out  1  hour chime pulse (held 0 when CHIME_EN undefined)
// BEHAVIOUR
//   Reset: all outputs 0; synchroniser and edge register 0; state BLANK.
//   States: BLANK -> RUN after SYNC_STAGES+1 clocks; RUN holds until reset.
//     BLANK: edge register tracks synchroniser output; no tick; setReady=0; advance ignored.
//     RUN: setReady=1.
//   Tick: rising edge of synchronised minuteToggle (falling edge ignored) -> one minute.
//     minuteOut updates on the (SYNC_STAGES+1)th rising clock edge after minuteToggle rises.
//   Increment: minute 59->0 carries hour+1; hour 11->0 wraps; no other carries.
//   tick and advance same cycle: +2 minutes, carry applied correctly (e.g. 11:59 -> 00:01).
//   Set transfer (setValid & setReady): legal values load next edge; outputs show them next cycle.
//     Out-of-range (minute>59 or hour>11): counters unchanged, setError=1 for one cycle.
//     Set wins over tick/advance in same cycle; those increments discarded, not deferred.
//   hourHandPos registered with counters (same-cycle update, no extra latency).
//   Reset mid-operation: immediate return to reset values, BLANK re-entered; in-flight set lost.
//   Widths: all arithmetic modulo 60/12 explicitly; never rely on 6/4-bit natural wrap.
// CONFIGURATION
//   HOUR_CHIME_EN defined: chime=1 for CHIME_CYCLES clocks starting the cycle minuteOut
//     becomes 0 via increment (not via set); new wrap during pulse restarts the count.
//   HOUR_CHIME_EN undefined: chime tied 0, no chime counter logic.
// TESTING
//   Reset with minuteToggle=1, release -> no tick, minuteOut=0, setReady=1 after 3 clocks.
//   Set 10:58, toggle 0->1 twice (falling between) -> 10:59 then 11:00, hourHandPos 54 then 55.
//   Set 11:59, advance coincident with tick -> 00:01; CHIME_EN: chime high 8 clocks.
//   setValid with setMinute=60 -> setError 1 cycle, time unchanged; setHour=12 same.
//   setValid 03:15 in same cycle as tick -> 03:15 exactly, hourHandPos=16.
//   Assert reset mid-set and mid-chime -> all outputs 0 immediately, setReady 0 for 3 clocks.

Source files
------------

// File: rtl/minute_hand_tracker.sv
// Wall-clock minute/hour tracker driven by an asynchronous minute toggle, with manual advance and set.
// Build with HOUR_CHIME_EN defined to include the hour chime pulse generator.
module minute_hand_tracker #(
   parameter int SYNC_STAGES  = 2,
   parameter int CHIME_CYCLES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       minuteToggle,
   input  logic       advance,
   input  logic       setValid,
   input  logic [5:0] setMinute,
   input  logic [3:0] setHour,
   output logic       setReady,
   output logic       setError,
   output logic [5:0] minuteOut,
   output logic [3:0] hourOut,
   output logic [5:0] hourHandPos,
   output logic       chime
);

   typedef enum logic {BLANK = 1'b0, RUN = 1'b1} state_t;

   localparam int CNT_W = $clog2(SYNC_STAGES + 2);

   if (SYNC_STAGES < 2 || CHIME_CYCLES < 1) begin : g_param_check
      $error("minute_hand_tracker: SYNC_STAGES must be >= 2 and CHIME_CYCLES >= 1");
   end

   function automatic logic [5:0] hand_pos(input logic [3:0] h, input logic [5:0] m);
      logic [6:0] pos;
      pos = ({3'd0, h} * 7'd5) + {1'b0, m / 6'd12};
      return pos[5:0];
   endfunction

   function automatic logic [3:0] hour_next(input logic [3:0] h);
      return (h >= 4'd11) ? 4'd0 : h + 4'd1;
   endfunction

   state_t                 state_q;
   logic [CNT_W-1:0]       blank_cnt_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic [5:0]             minute_q;
   logic [3:0]             hour_q;
   logic [5:0]             hand_q;
   logic                   ready_q;
   logic                   error_q;

   logic       sync_out;
   logic       tick;
   logic       adv;
   logic       set_fire;
   logic       set_legal;
   logic [1:0] steps;
   logic [6:0] sum;
   logic [5:0] minute_d;
   logic [3:0] hour_d;
   logic       error_d;

   always_comb begin
      sync_out  = sync_q[SYNC_STAGES-1];
      tick      = (state_q == RUN) && sync_out && !edge_q;
      adv       = (state_q == RUN) && advance;
      set_fire  = setValid && ready_q;
      set_legal = (setMinute <= 6'd59) && (setHour <= 4'd11);
      steps     = {1'b0, tick} + {1'b0, adv};
      sum       = {1'b0, minute_q} + {5'd0, steps};
      minute_d  = minute_q;
      hour_d    = hour_q;
      error_d   = 1'b0;
      // An accepted set (legal or not) swallows any same-cycle tick/advance.
      if (set_fire) begin
         if (set_legal) begin
            minute_d = setMinute;
            hour_d   = setHour;
         end else begin
            error_d = 1'b1;
         end
      end else if (sum >= 7'd60) begin
         minute_d = 6'(sum - 7'd60);
         hour_d   = hour_next(hour_q);
      end else begin
         minute_d = sum[5:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= BLANK;
         blank_cnt_q <= '0;
         sync_q      <= '0;
         edge_q      <= 1'b0;
         minute_q    <= 6'd0;
         hour_q      <= 4'd0;
         hand_q      <= 6'd0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], minuteToggle};
         edge_q <= sync_out;
         case (state_q)
            BLANK: begin
               // Let the synchroniser and edge register settle so a level held through reset is not seen as a tick.
               error_q <= 1'b0;
               if (blank_cnt_q == CNT_W'(SYNC_STAGES)) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  blank_cnt_q <= blank_cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               minute_q <= minute_d;
               hour_q   <= hour_d;
               hand_q   <= hand_pos(hour_d, minute_d);
               error_q  <= error_d;
            end
            default: state_q <= BLANK;
         endcase
      end
   end

   assign setReady    = ready_q;
   assign setError    = error_q;
   assign minuteOut   = minute_q;
   assign hourOut     = hour_q;
   assign hourHandPos = hand_q;

`ifdef HOUR_CHIME_EN
   localparam int CHIME_W = $clog2(CHIME_CYCLES + 1);

   logic               wrap;
   logic               chime_q;
   logic [CHIME_W-1:0] chime_cnt_q;

   // Only an increment crossing 59->0 chimes; a set landing on :00 does not.
   assign wrap = !set_fire && (sum >= 7'd60);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chime_q     <= 1'b0;
         chime_cnt_q <= '0;
      end else if (wrap) begin
         chime_q     <= 1'b1;
         chime_cnt_q <= CHIME_W'(CHIME_CYCLES - 1);
      end else if (chime_cnt_q != '0) begin
         chime_cnt_q <= chime_cnt_q - CHIME_W'(1);
      end else begin
         chime_q <= 1'b0;
      end
   end

   assign chime = chime_q;
`else
   assign chime = 1'b0;
`endif

endmodule
